// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, tracks in-flight IROM reads
// and queues returned {inst, pc} pairs for decode behind a valid/ready handshake.
module ifetch_queue #(
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter int          ROM_LAT  = 1,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst,
  output logic [ADDR_W-1:0]            irom_addr,
  input  logic [31:0]                  irom_inst,
  input  logic                         redirect_valid,
  input  logic [31:0]                  redirect_pc,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [31:0]                  deq_inst,
  output logic [31:0]                  deq_pc,
  output logic [31:0]                  deq_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fpc;
  logic [31:0]   in_flight;
  logic          issue;
  logic          ret_valid;
  logic [31:0]   ret_pc;
  logic          push;
  logic          pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic          unused_bits;

  assign irom_addr   = fpc[ADDR_W+1:2];
  assign unused_bits = ^{redirect_pc[1:0], fpc};

  // Credit check: a slot is reserved for every read still in the ROM pipe.
  assign issue     = ((in_flight + 32'(count)) < 32'(DEPTH)) && !redirect_valid;
  assign push      = ret_valid && !redirect_valid;
  assign deq_valid = (count != '0);
  assign pop       = deq_valid && deq_ready;

  if (ROM_LAT == 0) begin : g_comb
    assign ret_valid = issue;
    assign ret_pc    = fpc;
    assign in_flight = '0;
  end else begin : g_trk
    logic [ROM_LAT-1:0] trk_v;
    logic [31:0]        trk_pc [ROM_LAT];

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
        trk_v <= '0;
        for (int i = 0; i < ROM_LAT; i++) trk_pc[i] <= '0;
      end else begin
        trk_v[0]  <= issue;
        trk_pc[0] <= fpc;
        for (int i = 1; i < ROM_LAT; i++) begin
          trk_v[i]  <= trk_v[i-1] && !redirect_valid;
          trk_pc[i] <= trk_pc[i-1];
        end
      end
    end

    assign ret_valid = trk_v[ROM_LAT-1];
    assign ret_pc    = trk_pc[ROM_LAT-1];
    assign in_flight = 32'($countones(trk_v));
  end

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      mem_inst[wr_ptr] <= irom_inst;
      mem_pc[wr_ptr]   <= ret_pc;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      fpc    <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      fpc    <= {redirect_pc[31:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (issue) fpc <= fpc + 32'd4;
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Outputs read only registered storage; masked to zero while empty.
  assign deq_inst = deq_valid ? mem_inst[rd_ptr] : '0;
  assign deq_pc   = deq_valid ? mem_pc[rd_ptr] : '0;
  assign deq_pc4  = deq_valid ? (mem_pc[rd_ptr] + 32'd4) : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed ROM_LAT=1 scenarios, then a random
// ready/redirect sweep over ROM_LAT=0,2,3 against a PC-stream model.
module tb_ifetch_queue;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rom(input logic [15:0] a);
    return 32'h1000_0000 + {16'h0, a};
  endfunction

  // Directed DUT, ROM_LAT = 1
  logic        rst;
  logic [15:0] m_addr;
  logic [31:0] m_inst;
  logic        redir;
  logic [31:0] rpc;
  logic        m_valid;
  logic        ready;
  logic [31:0] m_dinst, m_dpc, m_dpc4;
  logic [2:0]  m_cnt;

  always @(posedge clk) m_inst <= rom(m_addr);

  ifetch_queue #(.ADDR_W(16), .DEPTH(4), .ROM_LAT(1), .RESET_PC(32'h0)) u_dut (
    .cpu_clk(clk), .cpu_rst(rst), .irom_addr(m_addr), .irom_inst(m_inst),
    .redirect_valid(redir), .redirect_pc(rpc), .deq_valid(m_valid), .deq_ready(ready),
    .deq_inst(m_dinst), .deq_pc(m_dpc), .deq_pc4(m_dpc4), .count(m_cnt)
  );

  // Sweep DUTs, shared stimulus
  logic        sw_on = 1'b0;
  logic        rst_s;
  logic        ready_s;
  logic        redir_s;
  logic [31:0] rpc_s;

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int LAT = (g == 0) ? 0 : g + 1;
    localparam int AI  = (LAT == 0) ? 0 : LAT - 1;
    logic [15:0] addr;
    logic [31:0] inst;
    logic        v;
    logic [31:0] dinst, dpc, dpc4;
    logic [2:0]  cnt;
    logic [15:0] apipe [4];
    logic [31:0] exp_pc = 32'h0;
    int          hs = 0;

    always @(posedge clk) begin
      apipe[0] <= addr;
      for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
    end
    assign inst = (LAT == 0) ? rom(addr) : rom(apipe[AI]);

    ifetch_queue #(.ADDR_W(16), .DEPTH(4), .ROM_LAT(LAT), .RESET_PC(32'h0)) u_dut (
      .cpu_clk(clk), .cpu_rst(rst_s), .irom_addr(addr), .irom_inst(inst),
      .redirect_valid(redir_s), .redirect_pc(rpc_s), .deq_valid(v), .deq_ready(ready_s),
      .deq_inst(dinst), .deq_pc(dpc), .deq_pc4(dpc4), .count(cnt)
    );

    always @(negedge clk) begin
      if (sw_on) begin
        if (!rst_s) begin
          exp_pc = 32'h0;
          check("sw_rst_valid", {31'h0, v}, 32'h0);
        end else begin
          check("sw_cnt_bound", {31'h0, (cnt <= 3'd4)}, 32'h1);
          if (v && ready_s) begin
            check("sw_pc", dpc, exp_pc);
            check("sw_inst", dinst, rom(exp_pc[17:2]));
            check("sw_pc4", dpc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            hs++;
          end
          if (redir_s) exp_pc = {rpc_s[31:2], 2'b00};
        end
      end
    end
  end

  initial begin
    rst = 1'b0; ready = 1'b0; redir = 1'b0; rpc = 32'h0;
    rst_s = 1'b0; ready_s = 1'b0; redir_s = 1'b0; rpc_s = 32'h0;
    tick(); tick();
    check("rst_valid", {31'h0, m_valid}, 32'h0);
    check("rst_count", {29'h0, m_cnt}, 32'h0);
    check("rst_pc", m_dpc, 32'h0);
    check("rst_inst", m_dinst, 32'h0);
    check("rst_pc4", m_dpc4, 32'h0);
    check("rst_addr", {16'h0, m_addr}, 32'h0);

    // Stream from reset: first entry two edges after issue begins
    rst = 1'b1; ready = 1'b1;
    tick();
    check("t1_lat_valid", {31'h0, m_valid}, 32'h0);
    check("t1_addr", {16'h0, m_addr}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t1_valid", {31'h0, m_valid}, 32'h1);
      check("t1_pc", m_dpc, 32'(4 * k));
      check("t1_inst", m_dinst, 32'h1000_0000 + 32'(k));
    end
    check("t1_pc4", m_dpc4, 32'd20);

    // Backpressure: queue fills, fetch address freezes
    ready = 1'b0;
    repeat (10) tick();
    check("t2_count_full", {29'h0, m_cnt}, 32'd4);
    check("t2_addr_frozen", {16'h0, m_addr}, 32'd8);
    tick();
    check("t2_addr_hold", {16'h0, m_addr}, 32'd8);
    ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("t2_valid", {31'h0, m_valid}, 32'h1);
      check("t2_pc", m_dpc, 32'd16 + 32'(4 * k));
      tick();
    end

    // Asynchronous reset mid-stream, then redirect with 3 queued + 1 in flight
    rst = 1'b0;
    #1;
    check("t3_async_valid", {31'h0, m_valid}, 32'h0);
    check("t3_async_count", {29'h0, m_cnt}, 32'h0);
    tick();
    rst = 1'b1; ready = 1'b0;
    repeat (4) tick();
    check("t3_count_pre", {29'h0, m_cnt}, 32'd3);
    redir = 1'b1; rpc = 32'h0000_0100;
    tick();
    redir = 1'b0; ready = 1'b1;
    check("t3_flush_valid", {31'h0, m_valid}, 32'h0);
    check("t3_flush_count", {29'h0, m_cnt}, 32'h0);
    tick();
    check("t3_gap_valid", {31'h0, m_valid}, 32'h0);
    tick();
    check("t3_first_valid", {31'h0, m_valid}, 32'h1);
    check("t3_first_pc", m_dpc, 32'h100);
    check("t3_first_inst", m_dinst, 32'h1000_0040);
    tick();
    check("t3_second_pc", m_dpc, 32'h104);
    check("t3_second_inst", m_dinst, 32'h1000_0041);
    tick();

    // Redirect together with a handshake
    check("t4_hs_pc", m_dpc, 32'h108);
    check("t4_hs_valid", {31'h0, m_valid}, 32'h1);
    redir = 1'b1; rpc = 32'h0000_0200;
    tick();
    redir = 1'b0;
    check("t4_no_dup", {31'h0, m_valid}, 32'h0);
    tick();
    check("t4_gap", {31'h0, m_valid}, 32'h0);
    tick();
    check("t4_target_pc", m_dpc, 32'h200);
    check("t4_target_valid", {31'h0, m_valid}, 32'h1);

    // Wrap at the top of the address space; low redirect bits dropped
    redir = 1'b1; rpc = 32'hFFFF_FFFB;
    tick();
    redir = 1'b0;
    tick(); tick();
    check("t5_pc0", m_dpc, 32'hFFFF_FFF8);
    check("t5_inst0", m_dinst, 32'h1000_FFFE);
    check("t5_pc4_0", m_dpc4, 32'hFFFF_FFFC);
    tick();
    check("t5_pc1", m_dpc, 32'hFFFF_FFFC);
    check("t5_inst1", m_dinst, 32'h1000_FFFF);
    check("t5_pc4_1", m_dpc4, 32'h0);
    tick();
    check("t5_pc2", m_dpc, 32'h0);
    check("t5_inst2", m_dinst, 32'h1000_0000);
    check("t5_pc4_2", m_dpc4, 32'h4);

    // Random sweep over the other ROM latencies
    sw_on = 1'b1;
    rst_s = 1'b1;
    for (int c = 0; c < 800; c++) begin
      ready_s = ($urandom_range(0, 3) != 0);
      redir_s = ($urandom_range(0, 40) == 0);
      rpc_s   = $urandom;
      rst_s   = (c == 400) ? 1'b0 : 1'b1;
      tick();
    end
    sw_on = 1'b0;
    check("sw_progress_l0", {31'h0, (g_sw[0].hs > 50)}, 32'h1);
    check("sw_progress_l2", {31'h0, (g_sw[1].hs > 50)}, 32'h1);
    check("sw_progress_l3", {31'h0, (g_sw[2].hs > 50)}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
